// File: rtl/uart_tx_mm.sv
// uart_tx_mm: memory-mapped UART transmitter with TX FIFO, programmable divisor and irq.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_mm #(
  parameter int DBITS   = 8,
  parameter int FIFO_AW = 4,
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tdo,
  output logic        irq
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [3:0] LAST = 4'(DBITS - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic r_par_en_l, r_par;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t r_state, w_state_n;
  logic [DBITS-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0] r_count;
  logic [DIV_W-1:0] r_div, r_div_l, r_cnt;
  logic [DBITS-1:0] r_shift;
  logic [3:0] r_bit;
  logic [31:0] r_rdata;
  logic r_tx_en, r_par_en, r_par_odd, r_two_stop, r_irq_en, r_ovf, r_two_l;
  logic w_full, w_empty, w_busy, w_pop, w_push, w_push_req, w_bit_end;
  logic [31:0] w_status, w_rmux;
  wire w_unused = ^writedata;
  wire w_wr = chipselect & write;
  assign w_full     = r_count == FULL_CNT;
  assign w_empty    = r_count == '0;
  assign w_busy     = r_state != IDLE;
  assign w_pop      = (r_state == IDLE) & r_tx_en & ~w_empty;
  assign w_push_req = w_wr & (address == 2'd0);
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_bit_end  = r_cnt == r_div_l - DIV_W'(1);
  assign w_status   = (32'(r_count) << 8) | {28'd0, r_ovf, w_busy, w_empty, w_full};
  assign w_rmux     = (address == 2'd1) ? w_status :
                      (address == 2'd2) ? {27'd0, r_irq_en, r_two_stop, r_par_odd, r_par_en, r_tx_en} :
                      (address == 2'd3) ? 32'(r_div) : 32'd0;
  assign readdata   = r_rdata;
  assign irq        = r_irq_en & ((w_empty & ~w_busy) | r_ovf);
  assign tdo        = (r_state == START) ? 1'b0 :
                      (r_state == DATA)  ? r_shift[0] :
`ifdef UART_TX_PARITY_EN
                      (r_state == PARITY) ? r_par :
`endif
                      1'b1;
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:   w_state_n = w_pop ? START : IDLE;
      START:  if (w_bit_end) w_state_n = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (w_bit_end && r_bit == LAST) w_state_n = r_par_en_l ? PARITY : STOP;
      PARITY: if (w_bit_end) w_state_n = STOP;
`else
      DATA:   if (w_bit_end && r_bit == LAST) w_state_n = STOP;
`endif
      STOP:   if (w_bit_end && (!r_two_l || r_bit[0])) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_state_n;
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= writedata[DBITS-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
      r_rdata <= '0;
      r_tx_en <= 1'b1;
      r_par_en <= 1'b0;
      r_par_odd <= 1'b0;
      r_two_stop <= 1'b0;
      r_irq_en <= 1'b0;
      r_div <= DIV_W'(DIV_RST);
    end else begin
      r_wptr <= r_wptr + FIFO_AW'(w_push);
      r_rptr <= r_rptr + FIFO_AW'(w_pop);
      r_count <= r_count + (FIFO_AW + 1)'(w_push) - (FIFO_AW + 1)'(w_pop);
      // a dropped push in the same cycle as a clear leaves ovf set
      r_ovf <= (w_push_req & w_full & ~w_pop) ? 1'b1 :
               (w_wr && address == 2'd1 && writedata[3]) ? 1'b0 : r_ovf;
      r_rdata <= (chipselect & read & ~write) ? w_rmux : '0;
      if (w_wr && address == 2'd2) begin
        r_tx_en <= writedata[0];
`ifdef UART_TX_PARITY_EN
        r_par_en <= writedata[1];
        r_par_odd <= writedata[2];
`endif
        r_two_stop <= writedata[3];
        r_irq_en <= writedata[4];
      end
      if (w_wr && address == 2'd3)
        r_div <= (writedata[DIV_W-1:0] < DIV_W'(2)) ? DIV_W'(2) : writedata[DIV_W-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_div_l <= DIV_W'(DIV_RST);
      r_two_l <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en_l <= 1'b0;
      r_par <= 1'b0;
`endif
    end else if (w_pop) begin
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= r_mem[r_rptr];
      r_div_l <= r_div;
      r_two_l <= r_two_stop;
`ifdef UART_TX_PARITY_EN
      r_par_en_l <= r_par_en;
      r_par <= (^r_mem[r_rptr]) ^ r_par_odd;
`endif
    end else if (w_busy) begin
      r_cnt <= w_bit_end ? '0 : r_cnt + DIV_W'(1);
      if (w_bit_end && r_state == DATA) begin
        r_shift <= r_shift >> 1;
        r_bit <= (r_bit == LAST) ? 4'd0 : r_bit + 4'd1;
      end
      if (w_bit_end && r_state == STOP) r_bit <= r_bit + 4'd1;
    end
  end
endmodule

// File: tb/tb_uart_tx_mm.sv
// tb_uart_tx_mm: directed self-checking bench for uart_tx_mm (default parameters).
module tb_uart_tx_mm;
  logic clk = 1'b0, reset = 1'b1, chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [1:0] address = '0;
  logic [31:0] writedata = '0, readdata, q;
  logic tdo, irq;
  logic [127:0] ev = '0;
  int en = 0, n_vec = 0, n_err = 0;
  uart_tx_mm dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata), .tdo(tdo), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask
  function automatic void add(input logic [15:0] b, input int nb, input int div);
    for (int i = 0; i < nb; i++)
      for (int d = 0; d < div; d++) begin
        ev[en] = b[i];
        en++;
      end
  endfunction
  task automatic cap(input string tag);
    logic [127:0] g;
    g = '0;
    for (int k = 0; k < en; k++) begin
      @(negedge clk);
      g[k] = tdo;
    end
    chk(tag, g, ev);
    ev = '0;
    en = 0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tdo", 128'(tdo), 128'(1));
    chk("rst_irq", 128'(irq), 128'(0));
    chk("rst_rdata", 128'(readdata), 128'(0));
    reset = 1'b0;
    rd(2'd1, q); chk("rst_status", 128'(q), 128'(32'h2));
    rd(2'd2, q); chk("rst_ctrl", 128'(q), 128'(32'h1));
    rd(2'd3, q); chk("rst_div", 128'(q), 128'(434));
    // divisor floor and read timing
    wr(2'd3, 32'd0);
    rd(2'd3, q); chk("div_floor", 128'(q), 128'(2));
    @(negedge clk); chk("rdata_idle", 128'(readdata), 128'(0));
    // basic 8N1 frame at divisor 4
    wr(2'd3, 32'd4);
    wr(2'd0, 32'h55);
    add({6'b0, 1'b1, 8'h55, 1'b0}, 10, 4); add(16'h1, 1, 1);
    cap("frame_55");
    rd(2'd1, q); chk("after_55", 128'(q), 128'(32'h2));
    wr(2'd0, 32'h55);
    rd(2'd1, q); chk("busy_55", 128'(q), 128'(32'h6));
    chk("busy_irq", 128'(irq), 128'(0));
    repeat (45) @(negedge clk);
    rd(2'd1, q); chk("done_55", 128'(q), 128'(32'h2));
    wr(2'd2, 32'h11);
    chk("irq_idle", 128'(irq), 128'(1));
    // two stop bits, back-to-back frames
    wr(2'd3, 32'd2);
    wr(2'd2, 32'h8);
    wr(2'd0, 32'hA3);
    wr(2'd0, 32'h3C);
    wr(2'd2, 32'h9);
    add({5'b0, 2'b11, 8'hA3, 1'b0}, 11, 2); add(16'h1, 1, 1);
    add({5'b0, 2'b11, 8'h3C, 1'b0}, 11, 2); add(16'h1, 1, 1);
    cap("two_stop");
`ifdef UART_TX_PARITY_EN
    wr(2'd2, 32'h3);
    wr(2'd0, 32'h07);
    add({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 2); add(16'h1, 1, 1);
    cap("par_even");
    wr(2'd2, 32'h7);
    wr(2'd0, 32'h07);
    add({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 2); add(16'h1, 1, 1);
    cap("par_odd");
`else
    wr(2'd2, 32'h7);
    rd(2'd2, q); chk("ctrl_nopar", 128'(q), 128'(32'h1));
    wr(2'd0, 32'h07);
    add({6'b0, 1'b1, 8'h07, 1'b0}, 10, 2); add(16'h1, 1, 1);
    cap("nopar_07");
`endif
    // tx_en cleared mid-frame: first frame finishes, second stays queued
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    wr(2'd2, 32'h1);
    wr(2'd2, 32'h0);
    repeat (40) @(negedge clk);
    rd(2'd1, q); chk("txen_stop", 128'(q), 128'(32'h100));
    wr(2'd2, 32'h1);
    repeat (30) @(negedge clk);
    // overflow with transmitter disabled
    wr(2'd2, 32'h10);
    chk("irq_empty", 128'(irq), 128'(1));
    for (int i = 0; i < 16; i++) wr(2'd0, 32'h0);
    rd(2'd1, q); chk("full16", 128'(q), 128'(32'h1001));
    chk("irq_full", 128'(irq), 128'(0));
    wr(2'd0, 32'h0);
    rd(2'd1, q); chk("ovf", 128'(q), 128'(32'h1009));
    chk("irq_ovf", 128'(irq), 128'(1));
    wr(2'd1, 32'h8);
    rd(2'd1, q); chk("ovf_clr", 128'(q), 128'(32'h1001));
    chk("irq_clr", 128'(irq), 128'(0));
    // reset in the middle of a data bit
    wr(2'd2, 32'h1);
    repeat (4) @(negedge clk);
    chk("mid_data", 128'(tdo), 128'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_tdo", 128'(tdo), 128'(1));
    reset = 1'b0;
    rd(2'd1, q); chk("rst2_status", 128'(q), 128'(32'h2));
    rd(2'd2, q); chk("rst2_ctrl", 128'(q), 128'(32'h1));
    rd(2'd3, q); chk("rst2_div", 128'(q), 128'(434));
    repeat (10) @(negedge clk);
    chk("rst2_idle", 128'(tdo), 128'(1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_mm.md
UART_TX_MM -- requirements
Module: uart_tx_mm

Interface
REQ-001 SHALL have parameter DBITS, 8, data bits per frame (5..9).
REQ-002 SHALL have parameter FIFO_AW, 4, FIFO address width; depth 2**FIFO_AW.
REQ-003 SHALL have parameter DIV_W, 16, baud divisor width.
REQ-004 SHALL have parameter DIV_RST, 434, divisor reset value in clocks per bit.
REQ-005 SHALL have ports: clk input 1 system clock; reset input 1 reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: address input 2 register select; chipselect input 1; read input 1; write input 1; writedata input 32; readdata output 32 registered.
REQ-007 SHALL have ports: tdo output 1 serial line, idle high; irq output 1 level interrupt.

Function
REQ-008 SHALL decode address 0 DATA, 1 STATUS, 2 CONTROL, 3 DIVISOR; access only when chipselect high; write has priority over read in the same cycle.
REQ-009 SHALL push writedata[DBITS-1:0] into the FIFO on a DATA write when not full; when full, the word SHALL be dropped and STATUS.ovf set.
REQ-010 SHALL accept a push to a full FIFO when a pop occurs in the same cycle; occupancy unchanged.
REQ-011 SHALL return readdata one cycle after a read strobe; 0 in any cycle without a read; DATA reads return 0.
REQ-012 SHALL present STATUS: [0] full, [1] empty, [2] busy (FSM not IDLE), [3] ovf sticky, [FIFO_AW+8:8] occupancy count 0..2**FIFO_AW; other bits 0.
REQ-013 SHALL clear ovf on a STATUS write with writedata[3]=1; other STATUS bits read-only; set and clear in the same cycle -> set wins.
REQ-014 SHALL present CONTROL: [0] tx_en, [1] par_en, [2] par_odd, [3] two_stop, [4] irq_en; other bits 0.
REQ-015 SHALL present DIVISOR [DIV_W-1:0]; written values below 2 SHALL be stored as 2.
REQ-016 SHALL implement FSM IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE; each bit lasts exactly DIVISOR clocks.
REQ-017 SHALL pop one word in IDLE when tx_en=1 and FIFO not empty; START (tdo=0) begins the following cycle.
REQ-018 SHALL shift data LSB first for DBITS bits; PARITY only when par_en: even -> XOR of data, odd -> its inverse.
REQ-019 SHALL hold STOP high for 1 bit, or 2 bits when two_stop; back-to-back frames SHALL have no extra idle cycle beyond the pop cycle.
REQ-020 SHALL latch divisor, par_en, par_odd, two_stop at pop; changes mid-frame apply to the next frame only.
REQ-021 SHALL finish the current frame when tx_en is cleared mid-frame, then stay in IDLE.
REQ-022 SHALL drive irq = irq_en & ((empty & ~busy) | ovf).

Reset
REQ-023 SHALL, on reset, set FIFO empty, occupancy 0, FSM IDLE, tdo=1, readdata=0, ovf=0, CONTROL=0x00000001, DIVISOR=DIV_RST, irq=0.
REQ-024 SHALL abort any frame in progress on reset; tdo SHALL be 1 the cycle after reset is sampled.

Configuration
REQ-025 SHALL compile parity support only when UART_TX_PARITY_EN is defined; defined -> REQ-018 parity behaviour; undefined -> no PARITY state, CONTROL[2:1] read 0 and ignore writes.

Verification
REQ-026 SHALL cover: DIVISOR=4, CONTROL=0x1, write DATA 0x55 -> tdo 0,1,0,1,0,1,0,1,0,1, each 4 clocks, 40 clocks total, busy then empty.
REQ-027 SHALL cover: par_en=1 par_odd=0, DIVISOR=2, write 0x07 -> parity bit 1 after data; par_odd=1 -> 0 (macro defined).
REQ-028 SHALL cover: tx_en=0, 17 writes with FIFO_AW=4 -> full=1, count 16, ovf=1, irq=1 if irq_en; STATUS write 0x8 -> ovf=0.
REQ-029 SHALL cover: two_stop=1, two queued words -> 2-bit high STOP, next START one cycle after STOP ends.
REQ-030 SHALL cover: reset asserted mid-DATA -> tdo=1 next cycle, FIFO empty, CONTROL=0x1, DIVISOR=434.
REQ-031 SHALL cover: DIVISOR write 0 then read -> readdata=2 one cycle after read strobe.
